// File: rtl/mem_port_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter_if
// Bundle of the two requester channels (a_*, b_*) and the shared memory port
// (mem_*) serviced by mem_port_arbiter.
//   slave  : arbiter view  (requests and mem_rd_data in; grants, read returns
//            and memory drive out)
//   master : requester/memory view (the mirror image of slave)
// ---------------------------------------------------------------------------
interface mem_port_arbiter_if #(
  parameter int N = 32
);
  // requester A
  logic         a_req;
  logic         a_wr;
  logic [N-1:0] a_addr;
  logic [N-1:0] a_wdata;
  logic         a_gnt;
  logic         a_rvalid;
  logic [N-1:0] a_rdata;
  // requester B
  logic         b_req;
  logic         b_wr;
  logic [N-1:0] b_addr;
  logic [N-1:0] b_wdata;
  logic         b_gnt;
  logic         b_rvalid;
  logic [N-1:0] b_rdata;
  // shared memory port
  logic         mem_wr_ena;
  logic [N-1:0] mem_addr;
  logic [N-1:0] mem_wr_data;
  logic [N-1:0] mem_rd_data;

  modport slave (
    input  a_req, a_wr, a_addr, a_wdata,
    input  b_req, b_wr, b_addr, b_wdata,
    input  mem_rd_data,
    output a_gnt, a_rvalid, a_rdata,
    output b_gnt, b_rvalid, b_rdata,
    output mem_wr_ena, mem_addr, mem_wr_data
  );

  modport master (
    output a_req, a_wr, a_addr, a_wdata,
    output b_req, b_wr, b_addr, b_wdata,
    output mem_rd_data,
    input  a_gnt, a_rvalid, a_rdata,
    input  b_gnt, b_rvalid, b_rdata,
    input  mem_wr_ena, mem_addr, mem_wr_data
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
// Shares one port of a synchronous memory between two requesters (A, B) with
// burst-limited round-robin. At most one access is granted per cycle; the
// winner's address / write enable / write data go to the memory and read data
// is routed back to the issuing requester RD_LATENCY cycles after its grant.
//
// Parameters
//   N          address and data width
//   RD_LATENCY cycles from grant edge to valid mem_rd_data (1..4)
//   MAX_BURST  consecutive grants one requester may hold while the other
//              waits (1..255)
// Ports
//   clk        clock, shared with the memory port
//   rstb       asynchronous active-low reset
//   bus        mem_port_arbiter_if.slave:
//                a_/b_ req, wr, addr, wdata   requests (held until gnt)
//                a_/b_ gnt                    combinational accept
//                a_/b_ rvalid, rdata          registered read return
//                mem_wr_ena, mem_addr, mem_wr_data, mem_rd_data
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int N          = 32,
  parameter int RD_LATENCY = 1,
  parameter int MAX_BURST  = 16
) (
  input  logic                  clk,
  input  logic                  rstb,
  mem_port_arbiter_if.slave     bus
);

  typedef logic [N-1:0] word_t;

  // IDLE: burst budget spent (cnt == MAX_BURST); OWN_x: x holds the port.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_A = 2'd1,
    OWN_B = 2'd2
  } state_e;

  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } req_e;

  localparam logic [7:0] MAX_CNT = 8'(MAX_BURST);

  state_e state_q, state_d;
  req_e   last_q,  last_d;
  logic [7:0] cnt_q, cnt_d;

  // read tag pipeline: valid bit and owner (1 = B) per granted read
  logic [RD_LATENCY-1:0] tag_vld_q, tag_vld_d;
  logic [RD_LATENCY-1:0] tag_own_q, tag_own_d;

  logic  a_gnt;
  logic  b_gnt;
  req_e  winner;
  word_t mem_addr;
  word_t mem_wr_data;
  logic  mem_wr_ena;
  logic  rd_issue;

  // -------------------------------------------------------------------------
  // Grant decision and state update
  // -------------------------------------------------------------------------
  always_comb begin
    a_gnt   = 1'b0;
    b_gnt   = 1'b0;
    winner  = last_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    state_d = state_q;

    if (bus.a_req && bus.b_req) begin
      unique case (state_q)
        OWN_A:   a_gnt = 1'b1;
        OWN_B:   b_gnt = 1'b1;
        default: begin
          // budget spent: hand the port to whoever was not served last
          if (last_q == REQ_A) b_gnt = 1'b1;
          else                 a_gnt = 1'b1;
        end
      endcase
    end else begin
      a_gnt = bus.a_req;
      b_gnt = bus.b_req;
    end

    if (a_gnt || b_gnt) begin
      winner = b_gnt ? REQ_B : REQ_A;
      if (winner == last_q) begin
        cnt_d = (cnt_q >= MAX_CNT) ? MAX_CNT : cnt_q + 8'd1;
      end else begin
        last_d = winner;
        cnt_d  = 8'd1;
      end
    end else begin
      // an idle cycle forfeits the burst, so the next contest flips
      cnt_d = MAX_CNT;
    end

    // state is a view of (last, cnt); kept registered so the grant mux
    // needs no counter compare on the request path
    if (cnt_d >= MAX_CNT)      state_d = IDLE;
    else if (last_d == REQ_A)  state_d = OWN_A;
    else                       state_d = OWN_B;
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q <= IDLE;
      last_q  <= REQ_B;
      cnt_q   <= MAX_CNT;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  // -------------------------------------------------------------------------
  // Memory drive
  // -------------------------------------------------------------------------
  always_comb begin
    mem_addr    = b_gnt ? bus.b_addr  : bus.a_addr;
    mem_wr_data = b_gnt ? bus.b_wdata : bus.a_wdata;
    mem_wr_ena  = (a_gnt & bus.a_wr) | (b_gnt & bus.b_wr);
    rd_issue    = (a_gnt & ~bus.a_wr) | (b_gnt & ~bus.b_wr);
  end

  // -------------------------------------------------------------------------
  // Read return tag pipeline
  // -------------------------------------------------------------------------
  always_comb begin
    tag_vld_d    = tag_vld_q;
    tag_own_d    = tag_own_q;
    tag_vld_d[0] = rd_issue;
    tag_own_d[0] = b_gnt;
    for (int unsigned i = 1; i < unsigned'(RD_LATENCY); i++) begin
      tag_vld_d[i] = tag_vld_q[i-1];
      tag_own_d[i] = tag_own_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      tag_vld_q <= '0;
      tag_own_q <= '0;
    end else begin
      tag_vld_q <= tag_vld_d;
      tag_own_q <= tag_own_d;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign bus.a_gnt       = a_gnt;
  assign bus.b_gnt       = b_gnt;
  assign bus.mem_addr    = mem_addr;
  assign bus.mem_wr_data = mem_wr_data;
  assign bus.mem_wr_ena  = mem_wr_ena;
  assign bus.a_rvalid    = tag_vld_q[RD_LATENCY-1] & ~tag_own_q[RD_LATENCY-1];
  assign bus.b_rvalid    = tag_vld_q[RD_LATENCY-1] &  tag_own_q[RD_LATENCY-1];
  assign bus.a_rdata     = bus.mem_rd_data;
  assign bus.b_rdata     = bus.mem_rd_data;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
// Three arbiters share one directed stimulus stream:
//   g_cfg[0]: RD_LATENCY=1, MAX_BURST=16
//   g_cfg[1]: RD_LATENCY=1, MAX_BURST=1
//   g_cfg[2]: RD_LATENCY=3, MAX_BURST=16
// Each has its own memory and a behavioural model compared every cycle.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;

  typedef struct {
    int          due;
    int          own;   // 1 = A, 2 = B
    logic [31:0] data;
  } rd_t;

  logic        clk = 1'b0;
  logic        rstb;
  logic        mem_load;
  logic        a_req, a_wr, b_req, b_wr;
  logic [31:0] a_addr, a_wdata, b_addr, b_wdata;

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : g_cfg
    localparam int L  = (g == 2) ? 3 : 1;
    localparam int MB = (g == 1) ? 1 : 16;

    mem_port_arbiter_if #(.N(32)) u_if ();

    mem_port_arbiter #(
      .N          (32),
      .RD_LATENCY (L),
      .MAX_BURST  (MB)
    ) u_dut (
      .clk  (clk),
      .rstb (rstb),
      .bus  (u_if)
    );

    assign u_if.a_req   = a_req;
    assign u_if.a_wr    = a_wr;
    assign u_if.a_addr  = a_addr;
    assign u_if.a_wdata = a_wdata;
    assign u_if.b_req   = b_req;
    assign u_if.b_wr    = b_wr;
    assign u_if.b_addr  = b_addr;
    assign u_if.b_wdata = b_wdata;

    // synchronous write-first memory with L-cycle read latency
    logic [31:0] mem     [16];
    logic [31:0] rd_pipe [L];
    always @(posedge clk) begin
      if (mem_load) begin
        for (int i = 0; i < 16; i++) mem[i] <= 32'hA000_0000 + 32'(i);
      end else if (u_if.mem_wr_ena) begin
        mem[u_if.mem_addr[3:0]] <= u_if.mem_wr_data;
      end
      rd_pipe[0] <= u_if.mem_wr_ena ? u_if.mem_wr_data : mem[u_if.mem_addr[3:0]];
      for (int i = 1; i < L; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign u_if.mem_rd_data = rd_pipe[L-1];

    // behavioural model
    logic [31:0] exp_mem [16];
    int          m_last;
    int          m_cnt;
    rd_t         pend [$];

    int          log_gnt  [256];
    int          log_rv   [256];
    logic [31:0] log_rd   [256];
    logic        log_we   [256];
    logic [31:0] log_addr [256];

    always @(negedge clk) begin
      int w;
      int ev;
      logic [31:0] ed;
      if (cyc < 256) begin
        log_gnt[cyc]  = (u_if.a_gnt === 1'b1 ? 1 : 0) + (u_if.b_gnt === 1'b1 ? 2 : 0);
        log_rv[cyc]   = (u_if.a_rvalid === 1'b1 ? 1 : 0) + (u_if.b_rvalid === 1'b1 ? 2 : 0);
        log_rd[cyc]   = u_if.a_rdata;
        log_we[cyc]   = u_if.mem_wr_ena;
        log_addr[cyc] = u_if.mem_addr;
      end
      if (mem_load) begin
        for (int i = 0; i < 16; i++) exp_mem[i] = 32'hA000_0000 + 32'(i);
      end
      if (!rstb) begin
        m_last = 2;
        m_cnt  = MB;
        pend.delete();
        chk($sformatf("i%0d reset a_rvalid", g), 32'(u_if.a_rvalid), 32'd0);
        chk($sformatf("i%0d reset b_rvalid", g), 32'(u_if.b_rvalid), 32'd0);
      end else begin
        w = 0;
        if (a_req && b_req)  w = (m_cnt < MB) ? m_last : 3 - m_last;
        else if (a_req)      w = 1;
        else if (b_req)      w = 2;
        chk($sformatf("i%0d a_gnt", g), 32'(u_if.a_gnt), 32'(w == 1));
        chk($sformatf("i%0d b_gnt", g), 32'(u_if.b_gnt), 32'(w == 2));
        chk($sformatf("i%0d mem_wr_ena", g), 32'(u_if.mem_wr_ena),
            32'((w == 1 && a_wr) || (w == 2 && b_wr)));
        if (w != 0) begin
          chk($sformatf("i%0d mem_addr", g), u_if.mem_addr, (w == 1) ? a_addr : b_addr);
          if ((w == 1) ? a_wr : b_wr)
            chk($sformatf("i%0d mem_wr_data", g), u_if.mem_wr_data, (w == 1) ? a_wdata : b_wdata);
        end

        ev = 0;
        ed = '0;
        if (pend.size() > 0 && pend[0].due == cyc) begin
          ev = pend[0].own;
          ed = pend[0].data;
          void'(pend.pop_front());
        end
        chk($sformatf("i%0d a_rvalid", g), 32'(u_if.a_rvalid), 32'(ev == 1));
        chk($sformatf("i%0d b_rvalid", g), 32'(u_if.b_rvalid), 32'(ev == 2));
        if (ev == 1) chk($sformatf("i%0d a_rdata", g), u_if.a_rdata, ed);
        if (ev == 2) chk($sformatf("i%0d b_rdata", g), u_if.b_rdata, ed);

        if (w != 0) begin
          if (w == 1 && a_wr)       exp_mem[a_addr[3:0]] = a_wdata;
          else if (w == 2 && b_wr)  exp_mem[b_addr[3:0]] = b_wdata;
          else pend.push_back('{cyc + L, w, exp_mem[(w == 1) ? a_addr[3:0] : b_addr[3:0]]});
          if (w == m_last) m_cnt = (m_cnt + 1 > MB) ? MB : m_cnt + 1;
          else begin
            m_last = w;
            m_cnt  = 1;
          end
        end else begin
          m_cnt = MB;
        end
      end
    end
  end

  task automatic step(input logic ar, input logic aw, input logic [31:0] aa, input logic [31:0] ad,
                      input logic br, input logic bw, input logic [31:0] ba, input logic [31:0] bd);
    a_req = ar; a_wr = aw; a_addr = aa; a_wdata = ad;
    b_req = br; b_wr = bw; b_addr = ba; b_wdata = bd;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
  endtask

  task automatic do_reset();
    rstb = 1'b0;
    idle(2);
    rstb = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, t1, t2, t3, t4, t5, t6, tn;
    int n;
    rstb = 1'b0;
    mem_load = 1'b1;
    a_req = 1'b0; a_wr = 1'b0; a_addr = '0; a_wdata = '0;
    b_req = 1'b0; b_wr = 1'b0; b_addr = '0; b_wdata = '0;
    @(posedge clk);
    #1;
    t0 = cyc;
    idle(3);
    mem_load = 1'b0;
    rstb = 1'b1;
    idle(1);

    // single read from A
    t1 = cyc;
    step(1'b1, 1'b0, 32'd5, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    idle(6);

    // continuous contention
    do_reset();
    t2 = cyc;
    repeat (40) step(1'b1, 1'b0, 32'd1, 32'd0, 1'b1, 1'b0, 32'd2, 32'd0);
    idle(1);
    t3 = cyc;
    repeat (4) step(1'b1, 1'b0, 32'd1, 32'd0, 1'b1, 1'b0, 32'd2, 32'd0);
    idle(1);

    // B writes, A reads back
    t4 = cyc;
    step(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b1, 32'd7, 32'hDEAD_BEEF);
    step(1'b1, 1'b0, 32'd7, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    idle(5);

    // interleaved single reads
    t5 = cyc;
    step(1'b1, 1'b0, 32'd1, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    step(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 32'd2, 32'd0);
    step(1'b1, 1'b0, 32'd3, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    idle(6);

    // reset with reads in flight
    t6 = cyc;
    step(1'b1, 1'b0, 32'd4, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    step(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 32'd5, 32'd0);
    do_reset();
    idle(4);
    tn = cyc;
    step(1'b1, 1'b0, 32'd8, 32'd0, 1'b1, 1'b0, 32'd9, 32'd0);
    idle(4);

    // literal expectations
    chk("reset rvalid i0", 32'(g_cfg[0].log_rv[t0]), 32'd0);
    chk("t1 a_gnt", 32'(g_cfg[0].log_gnt[t1]), 32'd1);
    chk("t1 mem_addr", g_cfg[0].log_addr[t1], 32'd5);
    chk("t1 rvalid L1", 32'(g_cfg[0].log_rv[t1+1]), 32'd1);
    chk("t1 rdata L1", g_cfg[0].log_rd[t1+1], 32'hA000_0005);
    chk("t1 early rvalid L3", 32'(g_cfg[2].log_rv[t1+2]), 32'd0);
    chk("t1 rvalid L3", 32'(g_cfg[2].log_rv[t1+3]), 32'd1);
    chk("t1 rdata L3", g_cfg[2].log_rd[t1+3], 32'hA000_0005);

    n = 0; for (int i = 0;  i < 16; i++) if (g_cfg[0].log_gnt[t2+i] == 1) n++;
    chk("burst A first 16", 32'(n), 32'd16);
    n = 0; for (int i = 16; i < 32; i++) if (g_cfg[0].log_gnt[t2+i] == 2) n++;
    chk("burst B next 16", 32'(n), 32'd16);
    n = 0; for (int i = 32; i < 40; i++) if (g_cfg[0].log_gnt[t2+i] == 1) n++;
    chk("burst A last 8", 32'(n), 32'd8);
    n = 0; for (int i = 0;  i < 40; i++) if (g_cfg[1].log_gnt[t2+i] == ((i % 2 == 0) ? 1 : 2)) n++;
    chk("alternate MB1", 32'(n), 32'd40);
    chk("recontest i0", 32'(g_cfg[0].log_gnt[t3]), 32'd2);
    chk("recontest i1", 32'(g_cfg[1].log_gnt[t3]), 32'd1);
    chk("recontest i1 next", 32'(g_cfg[1].log_gnt[t3+1]), 32'd2);

    chk("wr gnt B", 32'(g_cfg[0].log_gnt[t4]), 32'd2);
    chk("wr ena write cycle", 32'(g_cfg[0].log_we[t4]), 32'd1);
    chk("wr ena read cycle", 32'(g_cfg[0].log_we[t4+1]), 32'd0);
    chk("no rvalid for write", 32'(g_cfg[0].log_rv[t4+1]), 32'd0);
    chk("readback rvalid", 32'(g_cfg[0].log_rv[t4+2]), 32'd1);
    chk("readback data", g_cfg[0].log_rd[t4+2], 32'hDEAD_BEEF);

    chk("L3 rv 1", 32'(g_cfg[2].log_rv[t5+3]), 32'd1);
    chk("L3 rv 2", 32'(g_cfg[2].log_rv[t5+4]), 32'd2);
    chk("L3 rv 3", 32'(g_cfg[2].log_rv[t5+5]), 32'd1);
    chk("L3 rd 1", g_cfg[2].log_rd[t5+3], 32'hA000_0001);
    chk("L3 rd 2", g_cfg[2].log_rd[t5+4], 32'hA000_0002);
    chk("L3 rd 3", g_cfg[2].log_rd[t5+5], 32'hA000_0003);

    n = 0; for (int i = 2; i < 8; i++) n += g_cfg[2].log_rv[t6+i];
    chk("dropped reads L3", 32'(n), 32'd0);
    chk("dropped read L1", 32'(g_cfg[0].log_rv[t6+2]), 32'd0);
    chk("post-reset gnt i0", 32'(g_cfg[0].log_gnt[tn]), 32'd1);
    chk("post-reset gnt i1", 32'(g_cfg[1].log_gnt[tn]), 32'd1);
    chk("post-reset gnt i2", 32'(g_cfg[2].log_gnt[tn]), 32'd1);
    chk("post-reset rdata", g_cfg[0].log_rd[tn+1], 32'hA000_0008);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
